// File: rtl/sample_block_packer_if.sv
// Block stream interface between the sample packer and the SD block writer.
//   blk_data_out  : block word (producer -> consumer)
//   blk_valid_out : blk_data_out is valid
//   blk_first_out : current word is word 0 of a block
//   blk_last_out  : current word is the final word of a block
//   blk_ready_in  : consumer accepts the current word (consumer -> producer)
// Modports: master = packer side, slave = SD writer side.
interface sample_block_packer_if #(
    parameter int WORD_WIDTH = 8
);
    logic [WORD_WIDTH-1:0] blk_data_out;
    logic                  blk_valid_out;
    logic                  blk_first_out;
    logic                  blk_last_out;
    logic                  blk_ready_in;

    modport master (
        output blk_data_out,
        output blk_valid_out,
        output blk_first_out,
        output blk_last_out,
        input  blk_ready_in
    );

    modport slave (
        input  blk_data_out,
        input  blk_valid_out,
        input  blk_first_out,
        input  blk_last_out,
        output blk_ready_in
    );
endinterface

// File: rtl/sample_block_packer.sv
// Sample block packer: collects strobed audio samples into two ping-pong
// banks of BLOCK_WORDS words and streams each full bank out as one SD block.
//
// Ports:
//   clk_in           : system clock
//   rst_in           : asynchronous active-high reset
//   sample_in        : sample word from the clock-crossing stage
//   sample_strobe_in : level flag, each rising edge carries one new sample
//   rec_en_in        : record enable, samples accepted only while high
//   overflow_out     : sticky, set when a sample is dropped (both banks full)
//   fill_out         : word count of the bank currently being filled
//   blk_if           : block stream (master side), see sample_block_packer_if
//
// Build option: define SAMPLE_BLOCK_PACKER_FLUSH_EN to zero-pad a partial
// bank into a full block when rec_en_in falls; otherwise the partial fill
// is discarded.
//
// Read FSM states:
//   state  | meaning
//   IDLE   | waiting for the oldest bank to become full
//   PRIME  | one-cycle memory read of word 0
//   STREAM | presenting words, advancing on valid & ready
module sample_block_packer #(
    parameter int WORD_WIDTH  = 8,
    parameter int BLOCK_WORDS = 512
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic [WORD_WIDTH-1:0]        sample_in,
    input  logic                         sample_strobe_in,
    input  logic                         rec_en_in,
    output logic                         overflow_out,
    output logic [$clog2(BLOCK_WORDS):0] fill_out,
    sample_block_packer_if.master        blk_if
);
    localparam int IDX_W  = $clog2(BLOCK_WORDS);
    localparam int FILL_W = IDX_W + 1;

    typedef enum logic [1:0] {IDLE, PRIME, STREAM} rd_state_t;

    logic [WORD_WIDTH-1:0] mem_q [2*BLOCK_WORDS];

    logic              strobe_q, rec_en_q, overflow_q, wr_bank_q;
    logic              overflow_d, wr_bank_d;
    logic [1:0]        full_q, full_d;
    logic [FILL_W-1:0] fill_q, fill_d;
`ifdef SAMPLE_BLOCK_PACKER_FLUSH_EN
    logic              pad_q, pad_d;
`endif

    rd_state_t             state_q;
    logic                  rd_bank_q;
    logic [IDX_W-1:0]      rd_idx_q, rd_idx_inc;
    logic [WORD_WIDTH-1:0] data_q;
    logic                  valid_q, first_q, last_q;

    logic                  accept, rec_fall, both_full, drain_done, wr_en;
    logic [WORD_WIDTH-1:0] wr_data;

    assign accept     = sample_strobe_in & ~strobe_q & rec_en_in;
    assign rec_fall   = rec_en_q & ~rec_en_in;
    assign both_full  = full_q[0] & full_q[1];
    assign drain_done = (state_q == STREAM) & valid_q & blk_if.blk_ready_in & last_q;
    assign rd_idx_inc = rd_idx_q + 1'b1;

    always_comb begin
        wr_en      = 1'b0;
        wr_data    = sample_in;
        fill_d     = fill_q;
        overflow_d = overflow_q;
        full_d     = full_q;
`ifdef SAMPLE_BLOCK_PACKER_FLUSH_EN
        pad_d = pad_q;
        // While padding, incoming samples are ignored and never count as overflow.
        if (pad_q) begin
            wr_en   = 1'b1;
            wr_data = '0;
        end else if (rec_fall && fill_q != '0) begin
            pad_d = 1'b1;
        end else if (accept) begin
            if (both_full) overflow_d = 1'b1;
            else           wr_en      = 1'b1;
        end
`else
        if (rec_fall) begin
            fill_d = '0;
        end else if (accept) begin
            if (both_full) overflow_d = 1'b1;
            else           wr_en      = 1'b1;
        end
`endif
        if (wr_en) begin
            if (fill_q == FILL_W'(BLOCK_WORDS - 1)) begin
                fill_d            = '0;
                full_d[wr_bank_q] = 1'b1;
`ifdef SAMPLE_BLOCK_PACKER_FLUSH_EN
                pad_d = 1'b0;
`endif
            end else begin
                fill_d = fill_q + 1'b1;
            end
        end
        if (drain_done) full_d[rd_bank_q] = 1'b0;
        // Decided on next-state fullness so a bank freed by a drain in the
        // same cycle as a last-slot write is taken over immediately.
        wr_bank_d = wr_bank_q;
        if (full_d[wr_bank_q] && !full_d[~wr_bank_q]) wr_bank_d = ~wr_bank_q;
    end

    always_ff @(posedge clk_in) begin
        if (wr_en) mem_q[{wr_bank_q, fill_q[IDX_W-1:0]}] <= wr_data;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            strobe_q   <= 1'b0;
            rec_en_q   <= 1'b0;
            overflow_q <= 1'b0;
            wr_bank_q  <= 1'b0;
            full_q     <= '0;
            fill_q     <= '0;
`ifdef SAMPLE_BLOCK_PACKER_FLUSH_EN
            pad_q      <= 1'b0;
`endif
        end else begin
            strobe_q   <= sample_strobe_in;
            rec_en_q   <= rec_en_in;
            overflow_q <= overflow_d;
            wr_bank_q  <= wr_bank_d;
            full_q     <= full_d;
            fill_q     <= fill_d;
`ifdef SAMPLE_BLOCK_PACKER_FLUSH_EN
            pad_q      <= pad_d;
`endif
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            rd_bank_q <= 1'b0;
            rd_idx_q  <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            first_q   <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    rd_idx_q <= '0;
                    if (full_q[rd_bank_q]) state_q <= PRIME;
                end
                PRIME: begin
                    data_q  <= mem_q[{rd_bank_q, rd_idx_q}];
                    valid_q <= 1'b1;
                    first_q <= 1'b1;
                    last_q  <= 1'b0;
                    state_q <= STREAM;
                end
                STREAM: begin
                    if (valid_q && blk_if.blk_ready_in) begin
                        if (last_q) begin
                            valid_q   <= 1'b0;
                            first_q   <= 1'b0;
                            last_q    <= 1'b0;
                            rd_idx_q  <= '0;
                            rd_bank_q <= ~rd_bank_q;
                            state_q   <= full_q[~rd_bank_q] ? PRIME : IDLE;
                        end else begin
                            rd_idx_q <= rd_idx_inc;
                            data_q   <= mem_q[{rd_bank_q, rd_idx_inc}];
                            first_q  <= 1'b0;
                            last_q   <= (rd_idx_inc == IDX_W'(BLOCK_WORDS - 1));
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign blk_if.blk_data_out  = data_q;
    assign blk_if.blk_valid_out = valid_q;
    assign blk_if.blk_first_out = first_q;
    assign blk_if.blk_last_out  = last_q;
    assign overflow_out         = overflow_q;
    assign fill_out             = fill_q;
endmodule
